// File: rtl/lifo_rr_arbiter_if.sv
// Requester-side and LIFO-side signals of the LIFO round-robin arbiter.
// The arbiter takes the slave modport; the requesters and the LIFO take the master side.
interface lifo_rr_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        op;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic                    rvalid;
    logic [ID_W-1:0]         rid;
    logic                    lock_err;
    logic                    lifo_write;
    logic                    lifo_read;
    logic [DATA_W-1:0]       lifo_datain;
    logic [DATA_W-1:0]       lifo_dataout;
    logic                    lifo_val;
    logic                    lifo_full;

    modport slave (
        input  req, op, lock, wdata, lifo_dataout, lifo_val, lifo_full,
        output gnt, rdata, rvalid, rid, lock_err, lifo_write, lifo_read, lifo_datain
    );

    modport master (
        output req, op, lock, wdata, lifo_dataout, lifo_val, lifo_full,
        input  gnt, rdata, rvalid, rid, lock_err, lifo_write, lifo_read, lifo_datain
    );
endinterface

// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter sharing one LIFO between N_REQ push/pop requesters, with an
// optional timed exclusive lock per requester and tagged pop-data return.
module lifo_rr_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_W     = $clog2(N_REQ),
    parameter int unsigned LOCK_MAX = 15
) (
    input logic               clk,
    input logic               reset,
    lifo_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]  relock_blk_q, relock_blk_d;
    logic              lock_err_q, lock_err_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ID_W-1:0]   rid_q;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  gnt;
    logic              found;
    logic [ID_W-1:0]   win;
    logic              any_gnt;
    logic              win_pop;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Eligibility, then restriction to the lock owner while locked.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req[i] & (bus.op[i] ? bus.lifo_val : ~bus.lifo_full);
        end
        cand = elig;
        if (state_q == StLocked) begin
            cand = elig & (N_REQ'(1) << owner_q);
        end
    end

    // First candidate at or above ptr, wrapping.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!found && cand[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        gnt     = '0;
        any_gnt = 1'b0;
        win_pop = bus.op[win];
        if (reset && found) begin
            gnt     = N_REQ'(1) << win;
            any_gnt = 1'b1;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.lifo_write  = any_gnt & ~win_pop;
    assign bus.lifo_read   = any_gnt & win_pop;
    assign bus.lifo_datain = any_gnt ? bus.wdata[32'(win) * DATA_W +: DATA_W] : '0;
    assign bus.rdata       = rdata_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.rid         = rid_q;
    assign bus.lock_err    = lock_err_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = 1'b0;
        // A block clears once its requester is seen with lock low at an edge.
        relock_blk_d = relock_blk_q & bus.lock;
        unique case (state_q)
            StArb: begin
                if (found) begin
                    ptr_d = next_idx(win);
                    if (bus.lock[win] && !relock_blk_q[win]) begin
                        state_d    = StLocked;
                        owner_d    = win;
                        lock_cnt_d = '0;
                    end
                end
            end
            StLocked: begin
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (!bus.lock[owner_q]) begin
                    state_d    = StArb;
                    ptr_d      = next_idx(owner_q);
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == 8'(LOCK_MAX - 1)) begin
                    // Held for LOCK_MAX locked cycles: force release and bar re-lock.
                    state_d               = StArb;
                    ptr_d                 = next_idx(owner_q);
                    lock_cnt_d            = '0;
                    lock_err_d            = 1'b1;
                    relock_blk_d[owner_q] = 1'b1;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StArb;
            ptr_q        <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            relock_blk_q <= '0;
            lock_err_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rid_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            lock_err_q   <= lock_err_d;
            rvalid_q     <= bus.lifo_read;
            if (bus.lifo_read) begin
                rdata_q <= bus.lifo_dataout;
                rid_q   <= win;
            end
        end
    end

endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// Directed bench for lifo_rr_arbiter driving a small behavioural 8-deep LIFO.
module tb_lifo_rr_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned LM = 4;

    logic clk = 1'b0;
    logic reset;
    logic stub_clr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lifo_rr_arbiter_if #(.DATA_W(DW), .N_REQ(NR), .ID_W(IW)) bus ();

    lifo_rr_arbiter #(
        .DATA_W  (DW),
        .N_REQ   (NR),
        .ID_W    (IW),
        .LOCK_MAX(LM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // LIFO stand-in, depth 8
    logic [DW-1:0] stk [8];
    logic [3:0]    sp;
    logic [3:0]    spm1;

    always @(posedge clk) begin
        if (stub_clr) begin
            sp <= 4'd0;
        end else if (bus.lifo_write && sp != 4'd8) begin
            stk[sp[2:0]] <= bus.lifo_datain;
            sp           <= sp + 4'd1;
        end else if (bus.lifo_read && sp != 4'd0) begin
            sp <= sp - 4'd1;
        end
    end

    assign spm1             = sp - 4'd1;
    assign bus.lifo_val     = (sp != 4'd0);
    assign bus.lifo_full    = (sp == 4'd8);
    assign bus.lifo_dataout = (sp != 4'd0) ? stk[spm1[2:0]] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] o, input logic [3:0] l);
        bus.req  = r;
        bus.op   = o;
        bus.lock = l;
    endtask

    localparam logic [63:0] WD = {16'h4003, 16'h3002, 16'h2001, 16'h1000};
    logic [15:0] wv [4];

    initial begin
        wv[0] = 16'h1000; wv[1] = 16'h2001; wv[2] = 16'h3002; wv[3] = 16'h4003;
        reset = 1'b0; stub_clr = 1'b1; bus.wdata = WD;
        drive(4'b0000, 4'b0000, 4'b0000);
        tick(); tick();
        reset = 1'b1; stub_clr = 1'b0;

        // Round robin pushes 0,1,2,3,0,1,2,3 into an empty LIFO
        drive(4'b1111, 4'b0000, 4'b0000);
        for (int c = 0; c < 8; c++) begin
            #2;
            chk("rr_gnt", bus.gnt, 32'(1 << (c % 4)));
            chk("rr_datain", bus.lifo_datain, wv[c % 4]);
            chk("rr_write", bus.lifo_write, 1);
            chk("rr_read", bus.lifo_read, 0);
            tick();
        end

        // Full: pop by 0 wins, push by 1 must wait a cycle
        drive(4'b0011, 4'b0001, 4'b0000);
        #2; chk("full_gnt0", bus.gnt, 4'b0001); chk("full_read", bus.lifo_read, 1);
        chk("full_write", bus.lifo_write, 0);
        tick();
        drive(4'b0010, 4'b0000, 4'b0000);
        #2; chk("full_gnt1", bus.gnt, 4'b0010); chk("full_datain", bus.lifo_datain, 16'h2001);
        chk("full_rvalid", bus.rvalid, 1); chk("full_rdata", bus.rdata, 16'h4003);
        chk("full_rid", bus.rid, 0);
        tick();
        drive(4'b0000, 4'b0000, 4'b0000);
        #2; chk("full_rvalid_off", bus.rvalid, 0);

        // Reset held with all requesting pops from a non-empty LIFO
        reset = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_write", bus.lifo_write, 0);
            chk("rst_read", bus.lifo_read, 0);
            tick();
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_rdata", bus.rdata, 0);
        end
        reset = 1'b1;
        #2; chk("rst_first_gnt", bus.gnt, 4'b0001); chk("rst_first_read", bus.lifo_read, 1);
        tick();
        chk("rst_pop_rvalid", bus.rvalid, 1); chk("rst_pop_rdata", bus.rdata, 16'h2001);
        chk("rst_pop_rid", bus.rid, 0);
        drive(4'b0000, 4'b0000, 4'b0000);
        stub_clr = 1'b1; tick(); stub_clr = 1'b0;

        // Pop return: push A5A5 from 1, pop from 2
        bus.wdata = {16'h4003, 16'h3002, 16'hA5A5, 16'h1000};
        drive(4'b0010, 4'b0000, 4'b0000);
        #2; chk("pr_push_gnt", bus.gnt, 4'b0010); chk("pr_datain", bus.lifo_datain, 16'hA5A5);
        tick();
        drive(4'b0100, 4'b0100, 4'b0000);
        #2; chk("pr_pop_gnt", bus.gnt, 4'b0100); chk("pr_read", bus.lifo_read, 1);
        tick();
        chk("pr_rvalid", bus.rvalid, 1); chk("pr_rdata", bus.rdata, 16'hA5A5);
        chk("pr_rid", bus.rid, 2); chk("pr_val_drop", bus.lifo_val, 0);
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();
        chk("pr_rvalid_pulse", bus.rvalid, 0);
        bus.wdata = WD;

        // Empty: pop request is not granted
        drive(4'b0001, 4'b0001, 4'b0000);
        #2; chk("empty_gnt", bus.gnt, 0); chk("empty_read", bus.lifo_read, 0);
        tick();

        // Move ptr to 2, then requester 2 locks for three pushes
        drive(4'b1000, 4'b0000, 4'b0000);
        #2; chk("lk_pre3", bus.gnt, 4'b1000); tick();
        drive(4'b0010, 4'b0000, 4'b0000);
        #2; chk("lk_pre1", bus.gnt, 4'b0010); tick();
        drive(4'b1111, 4'b0000, 4'b0100);
        #2; chk("lk_gnt_a", bus.gnt, 4'b0100); chk("lk_datain", bus.lifo_datain, 16'h3002);
        tick();
        #2; chk("lk_gnt_b", bus.gnt, 4'b0100); tick();
        bus.lock = 4'b0000;
        #2; chk("lk_gnt_c", bus.gnt, 4'b0100); tick();
        bus.req = 4'b1011;
        #2; chk("lk_after", bus.gnt, 4'b1000); chk("lk_no_err", bus.lock_err, 0);
        tick();
        drive(4'b0000, 4'b0000, 4'b0000);
        stub_clr = 1'b1; tick(); stub_clr = 1'b0;

        // Timeout: requester 1 holds lock, requester 2 pops
        drive(4'b0110, 4'b0100, 4'b0010);
        #2; chk("to_arb_gnt", bus.gnt, 4'b0010); tick();
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("to_locked_gnt", bus.gnt, 4'b0010);
            chk("to_locked_err", bus.lock_err, 0);
            tick();
        end
        #2; chk("to_err_pulse", bus.lock_err, 1); chk("to_next_gnt", bus.gnt, 4'b0100);
        chk("to_next_read", bus.lifo_read, 1);
        tick();
        #2; chk("to_err_single", bus.lock_err, 0); chk("to_unlocked_gnt", bus.gnt, 4'b0010);
        chk("to_pop_rvalid", bus.rvalid, 1); chk("to_pop_rid", bus.rid, 2);
        tick();
        #2; chk("to_no_relock", bus.gnt, 4'b0100); tick();
        drive(4'b0000, 4'b0000, 4'b0000);
        #2; chk("to_idle", bus.gnt, 0); tick();
        drive(4'b0110, 4'b0100, 4'b0010);
        #2; chk("to_relock_gnt", bus.gnt, 4'b0010); tick();
        #2; chk("to_relocked", bus.gnt, 4'b0010); tick();

        // Reset mid-lock drops the lock silently
        reset = 1'b0;
        #2; chk("rl_gnt", bus.gnt, 0); tick();
        chk("rl_no_err", bus.lock_err, 0);
        reset = 1'b1;
        drive(4'b0100, 4'b0100, 4'b0010);
        #2; chk("rl_arb_gnt", bus.gnt, 4'b0100); tick();
        drive(4'b0000, 4'b0000, 4'b0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lifo_rr_arbiter.md
# lifo_rr_arbiter

Round-robin arbiter that shares one LIFO instance between N_REQ requesters, each of which may push or pop. It sits directly in front of the LIFO and owns its `write`, `read` and `datain` inputs. It returns popped data with a requester tag. An optional per-requester lock grants one requester exclusive, atomic access for push/pop sequences, bounded by a timeout.

## Interface
- DATA_W, 16, word width; matches the LIFO.
- N_REQ, 4, number of requesters, 2..16.
- ID_W, 2, requester index width, $clog2(N_REQ).
- LOCK_MAX, 15, maximum cycles a lock may be held before forced release, 1..255.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester request.
- op  in  N_REQ  per-requester operation: 0 = push, 1 = pop.
- lock  in  N_REQ  per-requester lock request, sampled when granted.
- wdata  in  N_REQ*DATA_W  push data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot grant, combinational; at most one bit set.
- rdata  out  DATA_W  popped word, registered.
- rvalid  out  1  rdata/rid valid, single-cycle pulse.
- rid  out  ID_W  index of the requester that issued the pop.
- lock_err  out  1  single-cycle pulse on forced lock release.
- lifo_write  out  1  to LIFO `write`.
- lifo_read  out  1  to LIFO `read`.
- lifo_datain  out  DATA_W  to LIFO `datain`.
- lifo_dataout  in  DATA_W  LIFO top-of-stack word, valid while lifo_val is high.
- lifo_val  in  1  LIFO non-empty.
- lifo_full  in  1  LIFO full.

## Operation
- Eligibility: requester i is eligible when req[i] is high and either:
  - op[i]=0 and lifo_full=0, or
  - op[i]=1 and lifo_val=1.
- Ineligible requesters are skipped without changing priority.
- ARB state: grant the first eligible requester scanning from ptr upward, wrapping modulo N_REQ.
  - After a grant to i, ptr becomes (i+1) mod N_REQ.
  - With no eligible requester, gnt=0 and ptr is held.
- Grant effects (cycle of the grant):
  - Push: lifo_write=1 and lifo_datain=wdata slice of the winner.
  - Pop: lifo_read=1.
  - lifo_write and lifo_read are never both high.
  - lifo_datain is the winner's slice whenever gnt≠0, otherwise 0.
- Pop return: on the granting edge, rdata<=lifo_dataout and rid<=winner. rvalid is high for exactly the following cycle.
- Lock:
  - Granted in ARB with lock[i]=1: move to LOCKED with owner=i and lock_cnt=0.
  - In LOCKED, only the owner can be granted, under the same eligibility rules; other requests wait.
  - ptr is frozen while LOCKED.
  - LOCKED→ARB when lock[owner]=0 on any edge. ptr becomes (owner+1) mod N_REQ.
  - lock_cnt increments on every LOCKED cycle.
  - When lock_cnt reaches LOCK_MAX: forced return to ARB, lock_err pulses for one cycle, ptr becomes owner+1.
  - A forced-released owner cannot re-enter LOCKED until it has deasserted lock for at least one cycle. It remains eligible for unlocked grants.
- Requester contract: req, op, wdata and lock are held stable from assertion until gnt[i] is seen. A request is consumed on the edge where gnt[i]=1.
- Reset low:
  - Registered outputs: ptr=0, state=ARB, owner=0, lock_cnt=0, rvalid=0, rdata=0, rid=0, lock_err=0, and the re-lock block flags are cleared.
  - Combinational outputs gnt, lifo_write, lifo_read and lifo_datain are forced to 0 during reset. This also applies when reset asserts mid-lock; the lock is dropped with no lock_err.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as an eligible req.
- Throughput: one operation per cycle.
- Pop data latency: 1 cycle. rvalid/rdata/rid are valid the cycle after gnt.
- Full/empty: eligibility uses the lifo_full/lifo_val values of the current cycle. A push and a pop never share a cycle, so no same-cycle hazard exists.
- Back-to-back pops by different requesters each produce an rvalid pulse, one per cycle, with the correct rid.
- State register, ptr, lock_cnt and all registered outputs update only on the rising edge of clk.

## Test plan
- Reset check: hold reset=0 for 3 cycles with req=4'b1111 and LIFO non-empty.
  - Required: gnt=0, lifo_write=0, lifo_read=0, rvalid=0, rdata=0 throughout.
  - Required: the first grant after release goes to requester 0.
- Round robin: req=4'b1111, op=4'b0000, LIFO empty, hold 8 cycles.
  - Required grants: 0,1,2,3,0,1,2,3.
  - Required pushes: wdata slices in that order.
- Pop return: push 16'hA5A5 from requester 1, then pop from requester 2.
  - Required: rvalid high the cycle after the pop grant, with rdata=16'hA5A5 and rid=2.
  - Required: lifo_val drops.
- Full/empty gating:
  - With LIFO full, req=4'b0011 with op=4'b01: only requester 0 (pop) is granted; requester 1 is granted the next cycle.
  - With LIFO empty, req=4'b0001 with op=4'b0001: no grant.
- Lock: requester 2 sets lock and pushes 3 words while req=4'b1111.
  - Required: gnt=4'b0100 for 3 cycles.
  - After lock drops, the next grant is to requester 3.
- Lock timeout: with LOCK_MAX=4, requester 1 holds lock and req indefinitely.
  - Required: the LOCKED state is exited at the LOCK_MAX boundary with a single lock_err pulse.
  - Required: requester 2 is granted next, and requester 1 does not re-lock until lock toggles.
